// File: rtl/tlbfill_pkg.sv
// Shared MMU definitions for the TLB fill path: page-type codes, PTE bit
// positions and the fill controller state encoding.
package tlbfill_pkg;

  localparam logic [1:0] PAGE_KILO = 2'b00;
  localparam logic [1:0] PAGE_MEGA = 2'b01;
  localparam logic [1:0] PAGE_GIGA = 2'b10;
  localparam logic [1:0] PAGE_TERA = 2'b11;

  localparam int PTE_G_BIT    = 5;
  localparam int PTE_N_BIT    = 63;
  localparam int PTE_NAPOT_LO = 10;
  localparam int PTE_NAPOT_HI = 13;
  localparam logic [3:0] PTE_NAPOT_PPN = 4'b1000;

  typedef enum logic {
    FILL_IDLE  = 1'b0,
    FILL_WRITE = 1'b1
  } fill_state_t;

endpackage

// File: rtl/tlbfill_plru.sv
// Tree pseudo-LRU for the TLB: ENTRIES-1 node bits in heap order, each
// pointing away from the most recently touched half of its subtree.
module tlbplru #(
  parameter int ENTRIES = 8,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          touch_en,
  input  logic [IW-1:0] touch_idx,
  output logic [IW-1:0] victim_idx
);

  logic [ENTRIES-2:0] tree_q;
  logic [ENTRIES-2:0] tree_d;
  logic [IW-1:0]      touch_node;
  logic [IW-1:0]      walk_node;
  logic               walk_bit;

  // Node at level l on the path to idx is (2^l - 1) + (idx >> (IW - l)).
  always_comb begin
    tree_d     = tree_q;
    touch_node = '0;
    if (touch_en) begin
      for (int l = 0; l < IW; l++) begin
        touch_node = IW'((1 << l) - 1) + IW'(touch_idx >> (IW - l));
        tree_d[touch_node] = ~touch_idx[IW-1-l];
      end
    end
  end

  always_comb begin
    victim_idx = '0;
    walk_node  = '0;
    walk_bit   = 1'b0;
    for (int l = 0; l < IW; l++) begin
      walk_bit = tree_q[walk_node];
      victim_idx[IW-1-l] = walk_bit;
      walk_node = IW'(2 * int'(walk_node) + 1 + int'(walk_bit));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tree_q <= '0;
    end else if (clear) begin
      tree_q <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

endmodule

// File: rtl/tlbfill.sv
// TLB fill/replacement controller: captures walker PTEs, picks a victim line,
// strobes its write enable and sequences flushes. Duplicate-line replacement
// is enabled by defining TLBFILL_DUP_REPLACE_EN.
module tlbfill
  import tlbfill_pkg::*;
#(
  parameter int TLB_ENTRIES = 8,
  parameter int XLEN = 64,
  parameter bit SVNAPOT_SUPPORTED = 1'b1,
  localparam int IW = $clog2(TLB_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   FillValid,
  output logic                   FillReady,
  input  logic [XLEN-1:0]        FillPTE,
  input  logic [1:0]             FillPageType,
  input  logic [TLB_ENTRIES-1:0] Matches,
  input  logic                   TLBAccess,
  input  logic                   TLBFlush,
  output logic [TLB_ENTRIES-1:0] WriteEnables,
  output logic [1:0]             PageTypeWriteVal,
  output logic                   PTE_G,
  output logic                   PTE_NAPOT,
  output logic                   LineFlush,
  output logic                   Busy,
  output fill_state_t            fsm_state
);

  fill_state_t            state_q;
  logic [TLB_ENTRIES-1:0] valid_q;
  logic [1:0]             pt_q;
  logic                   g_q;
  logic                   napot_q;

  logic                   pte_napot;
  logic [IW-1:0]          match_idx;
  logic [IW-1:0]          free_idx;
  logic [IW-1:0]          plru_victim;
  logic [IW-1:0]          victim_idx;
  logic                   any_match;
  logic                   all_valid;
  logic                   dup_hit;
  logic                   write_go;
  logic                   access_touch;
  logic                   unused_pte;

  assign unused_pte = ^FillPTE;

  if (XLEN == 64) begin : g_napot64
    assign pte_napot = SVNAPOT_SUPPORTED & FillPTE[PTE_N_BIT] &
                       (FillPTE[PTE_NAPOT_HI:PTE_NAPOT_LO] == PTE_NAPOT_PPN);
  end else begin : g_napot32
    assign pte_napot = 1'b0;
  end

  // Lowest-index priority encoders for matching and free lines.
  always_comb begin
    match_idx = '0;
    free_idx  = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (Matches[i])  match_idx = IW'(i);
      if (!valid_q[i]) free_idx  = IW'(i);
    end
  end

  assign any_match = |Matches;
  assign all_valid = &valid_q;

`ifdef TLBFILL_DUP_REPLACE_EN
  assign dup_hit = any_match;
`else
  assign dup_hit = 1'b0;
`endif

  assign victim_idx = dup_hit ? match_idx : (!all_valid ? free_idx : plru_victim);

  // Fill handshake: a PTE transfers on any cycle where FillValid and FillReady
  // are both high; FillReady never depends on FillValid.
  assign FillReady    = (state_q == FILL_IDLE) & ~TLBFlush;
  assign write_go     = (state_q == FILL_WRITE) & ~TLBFlush;
  assign access_touch = (state_q == FILL_IDLE) & TLBAccess & any_match & ~TLBFlush;
  assign WriteEnables = write_go ? (TLB_ENTRIES'(1) << victim_idx) : '0;
  assign LineFlush    = TLBFlush;
  assign Busy         = (state_q == FILL_WRITE);
  assign fsm_state    = state_q;

  assign PageTypeWriteVal = pt_q;
  assign PTE_G            = g_q;
  assign PTE_NAPOT        = napot_q;

  tlbplru #(
    .ENTRIES(TLB_ENTRIES)
  ) u_plru (
    .clk       (clk),
    .reset     (reset),
    .clear     (TLBFlush),
    .touch_en  (write_go | access_touch),
    .touch_idx (write_go ? victim_idx : match_idx),
    .victim_idx(plru_victim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL_IDLE;
      valid_q <= '0;
      pt_q    <= 2'b00;
      g_q     <= 1'b0;
      napot_q <= 1'b0;
    end else if (TLBFlush) begin
      // A fill captured before the flush is dropped, not retried.
      state_q <= FILL_IDLE;
      valid_q <= '0;
    end else begin
      case (state_q)
        FILL_IDLE: begin
          if (FillValid) begin
            pt_q    <= FillPageType;
            g_q     <= FillPTE[PTE_G_BIT];
            napot_q <= pte_napot;
            state_q <= FILL_WRITE;
          end
        end
        FILL_WRITE: begin
          valid_q[victim_idx] <= 1'b1;
          state_q <= FILL_IDLE;
        end
        default: state_q <= FILL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlbfill.sv
// Randomized scoreboard bench for tlbfill against a timestamp-based LRU-tree
// reference model.
module tb_tlbfill;
  import tlbfill_pkg::*;

  localparam int N  = 8;
  localparam int XL = 64;
  localparam int EW = N + 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          FillValid;
  logic          FillReady;
  logic [XL-1:0] FillPTE;
  logic [1:0]    FillPageType;
  logic [N-1:0]  Matches;
  logic          TLBAccess;
  logic          TLBFlush;
  logic [N-1:0]  WriteEnables;
  logic [1:0]    PageTypeWriteVal;
  logic          PTE_G;
  logic          PTE_NAPOT;
  logic          LineFlush;
  logic          Busy;
  fill_state_t   fsm_state;

  tlbfill #(.TLB_ENTRIES(N), .XLEN(XL), .SVNAPOT_SUPPORTED(1'b1)) dut (
    .clk(clk), .reset(reset), .FillValid(FillValid), .FillReady(FillReady),
    .FillPTE(FillPTE), .FillPageType(FillPageType), .Matches(Matches),
    .TLBAccess(TLBAccess), .TLBFlush(TLBFlush), .WriteEnables(WriteEnables),
    .PageTypeWriteVal(PageTypeWriteVal), .PTE_G(PTE_G), .PTE_NAPOT(PTE_NAPOT),
    .LineFlush(LineFlush), .Busy(Busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  bit mon_en = 0;
  bit have_cap = 0;
  logic [1:0] cur_pt;
  logic cur_g, cur_napot;

  // ---------------- reference model ----------------
  bit          mdl_valid[N];
  int unsigned mdl_ts[N];
  int unsigned mdl_now = 0;

  function automatic void mdl_clear();
    for (int i = 0; i < N; i++) begin
      mdl_valid[i] = 0;
      mdl_ts[i] = 0;
    end
  endfunction

  function automatic void mdl_touch(input int i);
    mdl_now++;
    mdl_ts[i] = mdl_now;
  endfunction

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Descend the halves, always heading for the half used less recently.
  function automatic int mdl_plru_victim();
    int lo, size, half;
    int unsigned ml, mr;
    lo = 0;
    size = N;
    while (size > 1) begin
      half = size / 2;
      ml = 0;
      mr = 0;
      for (int i = 0; i < half; i++) begin
        if (mdl_ts[lo + i] > ml) ml = mdl_ts[lo + i];
        if (mdl_ts[lo + half + i] > mr) mr = mdl_ts[lo + half + i];
      end
      if (ml > mr) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  function automatic int mdl_victim(input logic [N-1:0] m);
`ifdef TLBFILL_DUP_REPLACE_EN
    if (m != 0) return lowest(m);
`endif
    for (int i = 0; i < N; i++) if (!mdl_valid[i]) return i;
    return mdl_plru_victim();
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (WriteEnables != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(WriteEnables), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_strobe", 64'({WriteEnables, PageTypeWriteVal, PTE_G, PTE_NAPOT}), 64'(mon_e));
        end
      end
      if (have_cap)
        check("captured_fields", 64'({PageTypeWriteVal, PTE_G, PTE_NAPOT}), 64'({cur_pt, cur_g, cur_napot}));
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic fill(input logic [63:0] pte, input logic [1:0] pt, input logic [N-1:0] m,
                      input bit flush_in_write);
    int v;
    logic [N-1:0] we_exp;
    FillValid = 1'b1;
    FillPTE = pte;
    FillPageType = pt;
    Matches = m;
    TLBAccess = 1'b0;
    @(negedge clk);
    check("fill_ready_idle", 64'(FillReady), 64'd1);
    @(posedge clk);
    #1;
    FillValid = 1'b0;
    cur_pt = pt;
    cur_g = pte[5];
    cur_napot = pte[63] & (pte[13:10] == 4'b1000);
    have_cap = 1;
    if (flush_in_write) begin
      TLBFlush = 1'b1;
      @(negedge clk);
      check("line_flush_write", 64'(LineFlush), 64'd1);
      check("we_during_flush", 64'(WriteEnables), 64'd0);
      check("ready_flush_write", 64'(FillReady), 64'd0);
      @(posedge clk);
      #1;
      TLBFlush = 1'b0;
      mdl_clear();
    end else begin
      v = mdl_victim(m);
      we_exp = '0;
      we_exp[v] = 1'b1;
      exp_q.push_back({we_exp, pt, cur_g, cur_napot});
      mdl_valid[v] = 1;
      mdl_touch(v);
      @(negedge clk);
      check("busy_write", 64'(Busy), 64'd1);
      check("state_write", 64'(fsm_state), 64'(FILL_WRITE));
      check("ready_write", 64'(FillReady), 64'd0);
      @(posedge clk);
      #1;
    end
    Matches = '0;
  endtask

  task automatic access(input logic [N-1:0] m);
    int l;
    TLBAccess = 1'b1;
    Matches = m;
    @(posedge clk);
    #1;
    TLBAccess = 1'b0;
    Matches = '0;
    l = lowest(m);
    if (l >= 0) mdl_touch(l);
  endtask

  task automatic flush();
    TLBFlush = 1'b1;
    @(negedge clk);
    check("line_flush", 64'(LineFlush), 64'd1);
    @(posedge clk);
    #1;
    TLBFlush = 1'b0;
    mdl_clear();
  endtask

  function automatic logic [63:0] rand_pte();
    logic [63:0] p;
    p = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1) begin
      p[63] = 1'b1;
      p[13:10] = 4'b1000;
    end
    return p;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] p;
    int op;
    reset = 1'b1;
    FillValid = 1'b0;
    FillPTE = '0;
    FillPageType = 2'b00;
    Matches = '0;
    TLBAccess = 1'b0;
    TLBFlush = 1'b0;
    mdl_clear();

    @(negedge clk);
    check("rst_fill_ready", 64'(FillReady), 64'd1);
    check("rst_we", 64'(WriteEnables), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_fields", 64'({PageTypeWriteVal, PTE_G, PTE_NAPOT}), 64'd0);
    check("rst_line_flush_lo", 64'(LineFlush), 64'd0);
    TLBFlush = 1'b1;
    #1;
    check("rst_line_flush_hi", 64'(LineFlush), 64'd1);
    TLBFlush = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1;

    // Fill every line, then an access to line 0 steers the PLRU to line 4.
    for (int i = 0; i < N; i++) fill(rand_pte(), 2'($urandom_range(0, 3)), '0, 0);
    access(8'h01);
    fill(rand_pte(), 2'b00, '0, 0);

    // Refill from empty with no accesses: the next victim is line 0.
    flush();
    for (int i = 0; i < N; i++) fill(rand_pte(), 2'b01, '0, 0);
    fill(rand_pte(), 2'b10, '0, 0);

    // All lines valid, matching lines 2 and 5.
    fill(rand_pte(), 2'b11, 8'h24, 0);

    // NAPOT decode.
    p = 64'h8000_0000_0000_2020;
    fill(p, 2'b00, '0, 0);
    p = 64'h8000_0000_0000_1020;
    fill(p, 2'b01, '0, 0);

    // Flush in the WRITE cycle, then the next fill lands in line 0.
    fill(rand_pte(), 2'b10, '0, 1);
    fill(rand_pte(), 2'b00, '0, 0);

    // Fill offered together with a flush in IDLE is held off one cycle.
    FillValid = 1'b1;
    FillPTE = 64'h0000_0000_0000_0020;
    FillPageType = 2'b11;
    TLBFlush = 1'b1;
    @(negedge clk);
    check("ready_during_idle_flush", 64'(FillReady), 64'd0);
    check("line_flush_idle", 64'(LineFlush), 64'd1);
    @(posedge clk);
    #1;
    TLBFlush = 1'b0;
    mdl_clear();
    fill(64'h0000_0000_0000_0020, 2'b11, '0, 0);

    // Randomized mix.
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        fill(rand_pte(), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1) ? N'($urandom) : '0,
             ($urandom_range(0, 9) == 0));
      end else if (op <= 7) begin
        access(N'($urandom));
      end else if (op == 8) begin
        flush();
      end else begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlbfill.md
# tlbfill

Fill and replacement controller for the TLB. It accepts a translated PTE from the page table walker over a valid/ready handshake and chooses the victim line. It drives the per-line WriteEnable, PageTypeWriteVal, PTE_G and PTE_NAPOT inputs of the CAM lines, and sequences TLB flushes. The block sits between the walker and the CAM-line array. It consumes the array's per-line Match vector for duplicate replacement and for pseudo-LRU updates on lookup hits.

## Interface
- TLB_ENTRIES, 8, number of CAM lines; power of two, ≥2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- FillValid  in  1  walker presents a PTE
- FillReady  out  1  block accepts the PTE this cycle
- FillPTE  in  XLEN  leaf PTE from walker
- FillPageType  in  2  00 kilo, 01 mega, 10 giga, 11 tera
- Matches  in  TLB_ENTRIES  per-line Match from the CAM lines
- TLBAccess  in  1  translation lookup performed this cycle
- TLBFlush  in  1  sfence flush request
- WriteEnables  out  TLB_ENTRIES  one-hot line write strobe
- PageTypeWriteVal  out  2  registered FillPageType
- PTE_G  out  1  global bit of the captured PTE
- PTE_NAPOT  out  1  captured PTE is NAPOT
- LineFlush  out  1  flush to all CAM lines
- Busy  out  1  fill in progress (state WRITE)

## Operation
- States: IDLE, WRITE.
- IDLE:
  - FillReady = ~TLBFlush.
  - On FillValid & FillReady, register FillPTE and FillPageType, then go to WRITE.
- WRITE:
  - FillReady = 0.
  - Assert exactly one WriteEnables bit, for the victim line.
  - Set ValidVec[victim].
  - Mark the victim MRU in the PLRU.
  - Return to IDLE.
- Victim priority:
  - (1) If Matches is nonzero, the lowest-index matching line (duplicate replacement).
  - (2) Otherwise, the lowest-index line whose ValidVec bit is 0.
  - (3) Otherwise, the tree-PLRU victim.
- Victim is computed from Matches and ValidVec in the WRITE cycle.
- PTE decode:
  - PTE_G = PTE[5].
  - PTE_NAPOT = SVNAPOT_SUPPORTED & (XLEN==64) & PTE[63] & (PTE[13:10]==4'b1000).
  - PTE_NAPOT is 0 when XLEN==32.
- PLRU:
  - TLB_ENTRIES-1 tree bits; reset value all zeros, which points to index 0.
  - Each node bit points away from the most recently used half.
  - In IDLE, TLBAccess & |Matches marks the lowest-index matching line MRU.
- Flush (any state):
  - LineFlush = TLBFlush, combinational.
  - Next cycle: ValidVec = 0, PLRU = 0, state = IDLE.
  - A flush in WRITE forces WriteEnables = 0; the captured fill is dropped and is not re-presented.
- Simultaneous events:
  - Flush beats write; write beats access update.
  - TLBAccess is ignored in WRITE.

## Timing
- Handshake in cycle N; WriteEnables high in cycle N+1 only; FillReady high again in N+2.
- Back-to-back fills: one accepted every 2 cycles.
- Reset values:
  - FillReady = 1; WriteEnables = 0; Busy = 0.
  - PageTypeWriteVal, PTE_G and PTE_NAPOT = 0.
  - LineFlush follows TLBFlush.
- Reset mid-WRITE: the write is suppressed; ValidVec and PLRU are cleared.
- PageTypeWriteVal, PTE_G and PTE_NAPOT are stable from N+1 until the next accepted fill.

## Configuration
- TLBFILL_DUP_REPLACE_EN defined: victim priority (1) is active; an existing matching line is overwritten, so the TLB never holds duplicates.
- Undefined: Matches is ignored for victim selection (it still drives PLRU access updates), and priority starts at (2). The walker then guarantees no duplicate fills.

## Structure
- Shared MMU package holds:
  - page-type encoding localparams;
  - PTE bit positions: G = 5, N = 63, NAPOT PPN field [13:10] = 4'b1000.
- Sub-module tlbplru (tree PLRU):
  - state bits;
  - touch(index) update;
  - victim index output.
- Lowest-index selection uses the codebase priority-encoder primitives.

## Test plan
- Reset, then fill 8 distinct PTEs with Matches = 0 → WriteEnables = 0x01, 0x02, …, 0x80 in order; each strobe lasts one cycle, one cycle after its handshake.
- After the 8 fills, a 9th fill with no accesses → victim 0x01. Instead, a TLBAccess with Matches = 0x01 followed by a fill → victim 0x10.
- TLBFILL_DUP_REPLACE_EN defined, all lines valid, fill while Matches = 0x24 → WriteEnables = 0x04; with the macro undefined → PLRU victim.
- FillPTE with bit 63 = 1, [13:10] = 1000, bit 5 = 1, XLEN = 64 → PTE_NAPOT = 1 and PTE_G = 1 during the write cycle. With [13:10] = 0100 → PTE_NAPOT = 0.
- TLBFlush asserted in the WRITE cycle → LineFlush = 1, WriteEnables = 0, then FillReady = 1. The next fill goes to line 0x01.
- FillValid and TLBFlush together in IDLE → FillReady = 0, nothing captured; the fill is accepted the next cycle when TLBFlush is low.
